// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared encodings for the two-master wishbone arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_e;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  localparam int DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: counts unacknowledged strobe cycles and pulses expired at TIMEOUT
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stb,
  input  logic ack,
  output logic expired
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt;
  assign expired = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));
  always_ff @(posedge clk)
    if (rst || clear || ack || !stb || expired) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/wishbone_master_arbiter.sv
// wishbone_master_arbiter: round-robin, per-bus-cycle arbitration of two wishbone masters onto one port
module wishbone_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_we_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic [3:0]            m0_sel_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_int_o,
  input  logic                  m1_we_i,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic [3:0]            m1_sel_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_int_o,
  output logic                  s_we_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic [3:0]            s_sel_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_int_i
);
  arb_state_e state, state_n;
  logic last, g0, g1, expired;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = (m0_cyc_i && m1_cyc_i) ? (last == M1 ? GNT0 : GNT1) :
                m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    else if (g0 && !m0_cyc_i) state_n = m1_cyc_i ? GNT1 : IDLE;
    else if (g1 && !m1_cyc_i) state_n = m0_cyc_i ? GNT0 : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      last  <= M1;
    end else begin
      state <= state_n;
      if (state != IDLE && state_n != state) last <= g1;
    end
  assign s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  assign s_we_o  = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
  assign s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
  assign s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  // an ack arriving while reset is asserted belongs to an aborted tenure
  assign m0_ack_o = g0 && s_ack_i && !rst;
  assign m1_ack_o = g1 && s_ack_i && !rst;
  assign m0_err_o = g0 && expired && !rst;
  assign m1_err_o = g1 && expired && !rst;
  assign m0_dat_o = g0 ? s_dat_i : '0;
  assign m1_dat_o = g1 ? s_dat_i : '0;
  assign m0_int_o = s_int_i;
  assign m1_int_o = s_int_i;
  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_n != state),
    .stb     (s_stb_o),
    .ack     (s_ack_i),
    .expired (expired)
  );
endmodule

// File: doc/wishbone_master_arbiter.md
# wishbone_master_arbiter

Two-master arbiter placed between the wishbone masters and the single master port of `wishbone_interconnect`. It lets the host-command `wishbone_master` (the io handler) and a second master, such as a DMA or debug engine, share the bus to the slaves (DRT, GPIO, ...). Grants are round-robin and made per bus cycle: the winner holds the bus until it drops `cyc`. A watchdog flags a slave that never acknowledges.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width on all ports.
- `DATA_WIDTH`, 32, data width on all ports.
- `TIMEOUT`, 255, cycles a granted `stb` may wait for `ack` before `err` is pulsed; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `m0_we_i`, `m0_cyc_i`, `m0_stb_i`  in  1 each  master 0 (io handler) control.
- `m0_sel_i`  in  4  master 0 byte select.
- `m0_adr_i`  in  ADDR_WIDTH  master 0 address.
- `m0_dat_i`  in  DATA_WIDTH  master 0 write data.
- `m0_dat_o`  out  DATA_WIDTH  read data to master 0.
- `m0_ack_o`, `m0_err_o`, `m0_int_o`  out  1 each  ack, timeout error, interrupt to master 0.
- `m1_*`: identical set for master 1.
- `s_we_o`, `s_cyc_o`, `s_stb_o`  out  1 each  to interconnect.
- `s_sel_o`  out  4  byte select to interconnect.
- `s_adr_o`  out  ADDR_WIDTH  address to interconnect.
- `s_dat_o`  out  DATA_WIDTH  write data to interconnect.
- `s_dat_i`  in  DATA_WIDTH  read data from interconnect.
- `s_ack_i`, `s_int_i`  in  1 each  ack and interrupt from interconnect.

## Operation
- States: `IDLE`, `GNT0`, `GNT1`, held in a registered state register. A `last` register records the most recently granted master; reset value 1, so master 0 wins the first tie.
- In `IDLE`:
  - `m0_cyc_i` only -> `GNT0`.
  - `m1_cyc_i` only -> `GNT1`.
  - Both asserted -> grant the master that is not `last`.
  - Neither -> stay in `IDLE`.
- In `GNTn`: hold while `mn_cyc_i`=1; the grant is locked for the whole cycle, including multi-beat transfers. When `mn_cyc_i`=0:
  - If the other master's `cyc` is asserted, go directly to its grant on the same edge.
  - Otherwise go to `IDLE`.
  - `last` <= n on leaving.
- Forward path: `s_*_o` is a combinational mux of the granted master's inputs. In `IDLE`, all `s_*_o` are 0.
- Return path:
  - The granted master gets `s_dat_i` and `s_ack_i`.
  - The ungranted master gets `dat_o`=0 and `ack_o`=0.
  - `s_int_i` goes to both `m0_int_o` and `m1_int_o`, independent of the grant.
- Watchdog:
  - Counter clears when the state changes, on `s_ack_i`, or while `s_stb_o`=0.
  - Otherwise it increments while `s_stb_o`=1 && `s_ack_i`=0.
  - When count reaches `TIMEOUT`, `err_o` of the granted master pulses for one cycle and the counter clears.
  - The arbiter does not revoke the grant; the master must drop `cyc`.
- Reset: state <= `IDLE`, `last` <= 1, counter <= 0.

## Timing
- Reset values: all `s_*_o`, `m*_ack_o`, `m*_err_o`, and `m*_dat_o` are 0. `m*_int_o` follows `s_int_i`.
- Grant latency: 1 cycle. `cyc` rising at edge k gives `s_cyc_o` high after edge k+1, so a requesting master must hold `stb` until `ack`.
- Handoff:
  - Waiting master: 0 dead cycles between tenures.
  - Same master re-requesting with no competitor: 1 `IDLE` cycle.
- `ack` and data return are combinational, 0 added cycles.
- Simultaneous release and re-request by the same master while the other waits: the other master wins, because of round-robin.
- Reset mid-transfer: `s_cyc_o`/`s_stb_o` drop the cycle after the reset edge. Any in-flight `ack` is not forwarded.
- With `TIMEOUT`=N, `err` asserts exactly N cycles after `s_stb_o` first goes high with no `ack`.

## Structure
- Package `wb_arb_pkg`: state encoding (`IDLE`/`GNT0`/`GNT1`), master index constants, default `TIMEOUT`.
- Sub-module `wb_arb_watchdog`: counter with inputs `clear`, `stb`, `ack`, parameter `TIMEOUT`, and output `expired` pulse.
- The top holds the FSM and the muxes.

## Test plan
- Master 0 alone writes 0x0000_00FF to the GPIO output address: `s_cyc_o` goes high 1 cycle after `m0_cyc_i`, `gpio_out`=0x0000_00FF, `m0_ack_o` pulses, `m1_ack_o` stays 0.
- Both masters raise `cyc` on the same edge after reset: m0 is granted first; m1 is granted on the edge where `m0_cyc_i` falls, with 0 idle cycles.
- Both masters issue 4 back-to-back single reads from DRT address 0: grants alternate m0, m1, m0, m1, and each master receives DRT word 0 only on its own `ack`.
- m1 holds `cyc` over a 3-beat burst while m0 requests: m0 sees no `ack` until m1 drops `cyc`, and the `s_adr_o` sequence is m1's three addresses then m0's.
- `TIMEOUT`=8, m0 accesses an unmapped address that never acks: `m0_err_o` pulses exactly 8 cycles after `s_stb_o` rises. After m0 drops `cyc`, a waiting m1 is granted.
- Assert `rst` for 1 cycle while m1 is granted and mid-access: all `s_*_o` are 0 the next cycle. After reset, with both masters requesting, m0 is granted first.
